// File: rtl/cr_huf_comp_pkg.sv
// Shared Huffman-compressor typedefs: symbol kinds, plus the FIFO-arbiter
// state machine encoding and requester id type.
package cr_huf_comp_pkg;

   typedef enum logic [1:0] {HUF_LIT, HUF_LEN, HUF_DIST, HUF_EOB} huf_sym_kind_e;

   typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_e;

   typedef logic src_id_t;

   function automatic logic [1:0] srcOneHot(input src_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/cr_huf_comp_fifo_arb_if.sv
// Bundle of requester handshakes and shared-FIFO write-side signals seen by
// the two-requester frame arbiter (slave = arbiter, master = its environment).
interface cr_huf_comp_fifo_arb_if #(
   parameter int WIDTH  = 56,
   parameter int SLOT_W = 9
);
   logic              clear;
   logic              req0_valid;
   logic              req1_valid;
   logic [WIDTH-1:0]  req0_data;
   logic [WIDTH-1:0]  req1_data;
   logic              req0_eof;
   logic              req1_eof;
   logic              req0_ready;
   logic              req1_ready;
   logic              fifo_wen;
   logic [WIDTH+1:0]  fifo_wdata;
   logic              fifo_clear;
   logic              fifo_full;
   logic [SLOT_W-1:0] fifo_free_slots;
   logic              fifo_overflow;
   logic [1:0]        grant;
   logic              err;
   logic [15:0]       frames0;
   logic [15:0]       frames1;

   modport slave (
      input  clear, req0_valid, req1_valid, req0_data, req1_data, req0_eof, req1_eof,
             fifo_full, fifo_free_slots, fifo_overflow,
      output req0_ready, req1_ready, fifo_wen, fifo_wdata, fifo_clear,
             grant, err, frames0, frames1
   );

   modport master (
      output clear, req0_valid, req1_valid, req0_data, req1_data, req0_eof, req1_eof,
             fifo_full, fifo_free_slots, fifo_overflow,
      input  req0_ready, req1_ready, fifo_wen, fifo_wdata, fifo_clear,
             grant, err, frames0, frames1
   );

endinterface

// File: rtl/cr_huf_comp_rr_arb2.sv
// Two-way round-robin picker: with both requesters valid the one not served
// last wins; otherwise the single valid one wins.
module cr_huf_comp_rr_arb2
   import cr_huf_comp_pkg::*;
(
   input  logic [1:0] valid_i,
   input  src_id_t    last_i,
   output logic       any_o,
   output src_id_t    pick_o
);

   always_comb begin
      any_o  = |valid_i;
      pick_o = src_id_t'(1'b0);
      if (&valid_i) begin
         pick_o = src_id_t'(~last_i);
      end else begin
         pick_o = src_id_t'(~valid_i[0]);
      end
   end

endmodule

// File: rtl/cr_huf_comp_fifo_arb.sv
// Frame-level arbiter merging two beat streams into one shared FIFO; a grant
// lasts a whole frame and every FIFO write is issued from a flop.
module cr_huf_comp_fifo_arb
   import cr_huf_comp_pkg::*;
#(
   parameter int WIDTH    = 56,
   parameter int SLOT_W   = 9,
   parameter int MIN_FREE = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   cr_huf_comp_fifo_arb_if.slave  bus
);

   arb_state_e       state_q;
   logic [1:0]       grant_q;
   src_id_t          last_q;
   logic             wen_q;
   logic [WIDTH+1:0] wdata_q;
   logic             err_q;
   logic [15:0]      frames0_q;
   logic [15:0]      frames1_q;
   logic [15:0]      frames0_d;
   logic [15:0]      frames1_d;

   logic             rrAny;
   src_id_t          rrPick;
   logic             canWrite;
   logic             freeOk;
   logic             ready0;
   logic             ready1;
   logic             accept;
   src_id_t          acceptId;
   logic             acceptEof;
   logic [WIDTH-1:0] acceptData;
   logic             errHit;

   cr_huf_comp_rr_arb2 u_rr (
      .valid_i ({bus.req1_valid, bus.req0_valid}),
      .last_i  (last_q),
      .any_o   (rrAny),
      .pick_o  (rrPick)
   );

   // Free slots do not yet account for the write sitting in wdata_q.
   assign canWrite   = !bus.fifo_full && (bus.fifo_free_slots > SLOT_W'(wen_q));
   assign freeOk     = bus.fifo_free_slots >= SLOT_W'(MIN_FREE);
   assign ready0     = (state_q == ARB_XFER) && grant_q[0] && canWrite && !bus.clear;
   assign ready1     = (state_q == ARB_XFER) && grant_q[1] && canWrite && !bus.clear;
   assign accept     = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);
   assign acceptId   = src_id_t'(grant_q[1]);
   assign acceptEof  = grant_q[1] ? bus.req1_eof  : bus.req0_eof;
   assign acceptData = grant_q[1] ? bus.req1_data : bus.req0_data;
   assign frames0_d  = frames0_q + 16'd1;
   assign frames1_d  = frames1_q + 16'd1;

   assign errHit = bus.fifo_overflow ||
                   ((bus.fifo_free_slots == '0) &&
                    ((grant_q[0] && bus.req0_valid && !ready0) ||
                     (grant_q[1] && bus.req1_valid && !ready1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         grant_q   <= 2'b00;
         last_q    <= src_id_t'(1'b1);
         wen_q     <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         frames0_q <= 16'd0;
         frames1_q <= 16'd0;
      end else if (bus.clear) begin
         state_q <= ARB_IDLE;
         grant_q <= 2'b00;
         wen_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         wen_q <= accept;
         if (accept) begin
            wdata_q <= {acceptId, acceptEof, acceptData};
         end
         if (errHit) begin
            err_q <= 1'b1;
         end
         case (state_q)
            ARB_IDLE: begin
               if (rrAny && freeOk) begin
                  grant_q <= srcOneHot(rrPick);
                  state_q <= ARB_XFER;
               end
            end
            ARB_XFER: begin
               if (accept && acceptEof) begin
                  state_q <= ARB_IDLE;
                  grant_q <= 2'b00;
                  last_q  <= acceptId;
                  if (acceptId) begin
                     frames1_q <= frames1_d;
                  end else begin
                     frames0_q <= frames0_d;
                  end
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.fifo_wen   = wen_q;
   assign bus.fifo_wdata = wdata_q;
   assign bus.fifo_clear = bus.clear;
   assign bus.grant      = grant_q;
   assign bus.err        = err_q;
   assign bus.frames0    = frames0_q;
   assign bus.frames1    = frames1_q;

endmodule

// File: tb/tb_cr_huf_comp_fifo_arb.sv
// Directed bench for the two-requester FIFO arbiter: a per-cycle vector table
// plus hand sequences for reset, counter wrap and mid-frame reset.
module tb_cr_huf_comp_fifo_arb;

   localparam int WIDTH    = 56;
   localparam int SLOT_W   = 9;
   localparam int MIN_FREE = 4;
   localparam int NVEC     = 27;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int compareCount = 0;
   int failCount    = 0;

   cr_huf_comp_fifo_arb_if #(.WIDTH(WIDTH), .SLOT_W(SLOT_W)) bus ();

   cr_huf_comp_fifo_arb #(
      .WIDTH    (WIDTH),
      .SLOT_W   (SLOT_W),
      .MIN_FREE (MIN_FREE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              clr, v0, e0, v1, e1, full, ovf;
      logic [7:0]        d0, d1;
      logic [SLOT_W-1:0] free;
      logic              r0, r1, wen, ws, we;
      logic [7:0]        wd;
      logic [1:0]        gnt;
      logic              err;
      logic [15:0]       f0, f1;
   } vec_t;

   vec_t vecs [NVEC];

   function automatic vec_t mkVec(
      input logic clr, input logic v0, input logic [7:0] d0, input logic e0,
      input logic v1, input logic [7:0] d1, input logic e1, input logic full,
      input int free, input logic ovf,
      input logic r0, input logic r1, input logic wen, input logic ws, input logic we,
      input logic [7:0] wd, input logic [1:0] gnt, input logic err,
      input logic [15:0] f0, input logic [15:0] f1);
      vec_t v;
      v.clr = clr; v.v0 = v0; v.d0 = d0; v.e0 = e0;
      v.v1 = v1; v.d1 = d1; v.e1 = e1; v.full = full;
      v.free = SLOT_W'(free); v.ovf = ovf;
      v.r0 = r0; v.r1 = r1; v.wen = wen; v.ws = ws; v.we = we;
      v.wd = wd; v.gnt = gnt; v.err = err; v.f0 = f0; v.f1 = f1;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      compareCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.clear           = v.clr;
      bus.req0_valid      = v.v0;
      bus.req0_data       = WIDTH'(v.d0);
      bus.req0_eof        = v.e0;
      bus.req1_valid      = v.v1;
      bus.req1_data       = WIDTH'(v.d1);
      bus.req1_eof        = v.e1;
      bus.fifo_full       = v.full;
      bus.fifo_free_slots = v.free;
      bus.fifo_overflow   = v.ovf;
   endtask

   task automatic checkRow(input int i, input vec_t v);
      logic [WIDTH+1:0] expW;
      expW = {v.ws, v.we, WIDTH'(v.wd)};
      checkOutput($sformatf("row%0d ready0", i),     64'(bus.req0_ready), 64'(v.r0));
      checkOutput($sformatf("row%0d ready1", i),     64'(bus.req1_ready), 64'(v.r1));
      checkOutput($sformatf("row%0d fifo_wen", i),   64'(bus.fifo_wen),   64'(v.wen));
      checkOutput($sformatf("row%0d fifo_wdata", i), 64'(bus.fifo_wdata), 64'(expW));
      checkOutput($sformatf("row%0d fifo_clear", i), 64'(bus.fifo_clear), 64'(v.clr));
      checkOutput($sformatf("row%0d grant", i),      64'(bus.grant),      64'(v.gnt));
      checkOutput($sformatf("row%0d err", i),        64'(bus.err),        64'(v.err));
      checkOutput($sformatf("row%0d frames0", i),    64'(bus.frames0),    64'(v.f0));
      checkOutput($sformatf("row%0d frames1", i),    64'(bus.frames1),    64'(v.f1));
   endtask

   task automatic idleInputs();
      bus.clear           = 1'b0;
      bus.req0_valid      = 1'b0;
      bus.req0_data       = '0;
      bus.req0_eof        = 1'b0;
      bus.req1_valid      = 1'b0;
      bus.req1_data       = '0;
      bus.req1_eof        = 1'b0;
      bus.fifo_full       = 1'b0;
      bus.fifo_free_slots = '0;
      bus.fifo_overflow   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      //              clr v0 d0    e0 v1 d1    e1 fl free ov | r0 r1 wen ws we wd     gnt    err f0 f1
      vecs[0]  = mkVec(0, 1, 8'hA1, 0, 1, 8'hB1, 0, 0, 16, 0,  0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 0, 0);
      vecs[1]  = mkVec(0, 1, 8'hA1, 0, 1, 8'hB1, 0, 0, 16, 0,  1, 0, 0, 0, 0, 8'h00, 2'b01, 0, 0, 0);
      vecs[2]  = mkVec(0, 1, 8'hA2, 0, 1, 8'hB1, 0, 0, 16, 0,  1, 0, 1, 0, 0, 8'hA1, 2'b01, 0, 0, 0);
      vecs[3]  = mkVec(0, 1, 8'hA3, 1, 1, 8'hB1, 0, 0, 16, 0,  1, 0, 1, 0, 0, 8'hA2, 2'b01, 0, 0, 0);
      vecs[4]  = mkVec(0, 1, 8'hA4, 0, 1, 8'hB1, 0, 0, 16, 0,  0, 0, 1, 0, 1, 8'hA3, 2'b00, 0, 1, 0);
      vecs[5]  = mkVec(0, 1, 8'hA4, 0, 1, 8'hB1, 0, 0, 16, 0,  0, 1, 0, 0, 1, 8'hA3, 2'b10, 0, 1, 0);
      vecs[6]  = mkVec(0, 1, 8'hA4, 0, 1, 8'hB2, 0, 0, 16, 0,  0, 1, 1, 1, 0, 8'hB1, 2'b10, 0, 1, 0);
      vecs[7]  = mkVec(0, 1, 8'hA4, 0, 1, 8'hB3, 1, 0, 16, 0,  0, 1, 1, 1, 0, 8'hB2, 2'b10, 0, 1, 0);
      vecs[8]  = mkVec(0, 1, 8'hA4, 1, 0, 8'h00, 0, 0, 16, 0,  0, 0, 1, 1, 1, 8'hB3, 2'b00, 0, 1, 1);
      vecs[9]  = mkVec(0, 1, 8'hA4, 1, 0, 8'h00, 0, 0, 16, 0,  1, 0, 0, 1, 1, 8'hB3, 2'b01, 0, 1, 1);
      vecs[10] = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 16, 0,  0, 0, 1, 0, 1, 8'hA4, 2'b00, 0, 2, 1);
      vecs[11] = mkVec(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0,  3, 0,  0, 0, 0, 0, 1, 8'hA4, 2'b00, 0, 2, 1);
      vecs[12] = mkVec(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0,  3, 0,  0, 0, 0, 0, 1, 8'hA4, 2'b00, 0, 2, 1);
      vecs[13] = mkVec(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0,  4, 0,  0, 0, 0, 0, 1, 8'hA4, 2'b00, 0, 2, 1);
      vecs[14] = mkVec(0, 1, 8'hA5, 0, 0, 8'h00, 0, 0,  4, 0,  1, 0, 0, 0, 1, 8'hA4, 2'b01, 0, 2, 1);
      vecs[15] = mkVec(0, 1, 8'hA6, 0, 0, 8'h00, 0, 0,  1, 0,  0, 0, 1, 0, 0, 8'hA5, 2'b01, 0, 2, 1);
      vecs[16] = mkVec(0, 1, 8'hA6, 0, 0, 8'h00, 0, 0,  1, 0,  1, 0, 0, 0, 0, 8'hA5, 2'b01, 0, 2, 1);
      vecs[17] = mkVec(0, 1, 8'hA7, 0, 0, 8'h00, 0, 0,  0, 0,  0, 0, 1, 0, 0, 8'hA6, 2'b01, 0, 2, 1);
      vecs[18] = mkVec(0, 1, 8'hA7, 0, 0, 8'h00, 0, 0,  0, 0,  0, 0, 0, 0, 0, 8'hA6, 2'b01, 1, 2, 1);
      vecs[19] = mkVec(0, 1, 8'hA7, 0, 0, 8'h00, 0, 1,  8, 0,  0, 0, 0, 0, 0, 8'hA6, 2'b01, 1, 2, 1);
      vecs[20] = mkVec(1, 1, 8'hA7, 1, 0, 8'h00, 0, 0,  8, 0,  0, 0, 0, 0, 0, 8'hA6, 2'b01, 1, 2, 1);
      vecs[21] = mkVec(0, 0, 8'h00, 0, 1, 8'hB4, 1, 0,  8, 0,  0, 0, 0, 0, 0, 8'hA6, 2'b00, 0, 2, 1);
      vecs[22] = mkVec(1, 0, 8'h00, 0, 1, 8'hB4, 1, 0,  8, 0,  0, 0, 0, 0, 0, 8'hA6, 2'b10, 0, 2, 1);
      vecs[23] = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8, 1,  0, 0, 0, 0, 0, 8'hA6, 2'b00, 0, 2, 1);
      vecs[24] = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8, 0,  0, 0, 0, 0, 0, 8'hA6, 2'b00, 1, 2, 1);
      vecs[25] = mkVec(1, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8, 0,  0, 0, 0, 0, 0, 8'hA6, 2'b00, 1, 2, 1);
      vecs[26] = mkVec(0, 0, 8'h00, 0, 0, 8'h00, 0, 0,  8, 0,  0, 0, 0, 0, 0, 8'hA6, 2'b00, 0, 2, 1);

      // Reset state, with a requester already valid to show ready stays low.
      idleInputs();
      bus.req0_valid      = 1'b1;
      bus.fifo_free_slots = SLOT_W'(16);
      @(negedge clk);
      #1;
      checkOutput("reset ready0",     64'(bus.req0_ready), 64'd0);
      checkOutput("reset grant",      64'(bus.grant),      64'd0);
      checkOutput("reset fifo_wen",   64'(bus.fifo_wen),   64'd0);
      checkOutput("reset fifo_wdata", 64'(bus.fifo_wdata), 64'd0);
      checkOutput("reset err",        64'(bus.err),        64'd0);
      checkOutput("reset frames0",    64'(bus.frames0),    64'd0);
      checkOutput("reset frames1",    64'(bus.frames1),    64'd0);
      @(negedge clk);
      idleInputs();
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkRow(i, vecs[i]);
      end

      // Counter wrap: preload frames0 just below the top, then two one-beat frames.
      @(negedge clk);
      force dut.frames0_q = 16'hFFFE;
      idleInputs();
      bus.req0_valid      = 1'b1;
      bus.req0_eof        = 1'b1;
      bus.req0_data       = WIDTH'(8'hC1);
      bus.fifo_free_slots = SLOT_W'(16);
      #1;
      release dut.frames0_q;
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("wrap frames0 ffff", 64'(bus.frames0),    64'hFFFF);
      checkOutput("wrap wdata c1",     64'(bus.fifo_wdata), {6'd0, 1'b0, 1'b1, 56'hC1});
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("wrap frames0 zero", 64'(bus.frames0), 64'd0);
      checkOutput("wrap frames1 kept", 64'(bus.frames1), 64'd1);
      bus.req0_valid = 1'b0;
      bus.req0_eof   = 1'b0;

      // Reset in the middle of a frame abandons it with no further writes.
      @(negedge clk);
      bus.req0_valid = 1'b1;
      bus.req0_data  = WIDTH'(8'hD1);
      @(negedge clk);
      #1;
      checkOutput("midrst ready0 pre", 64'(bus.req0_ready), 64'd1);
      @(negedge clk);
      bus.req0_data = WIDTH'(8'hD2);
      #1;
      checkOutput("midrst wen pre", 64'(bus.fifo_wen), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst fifo_wen", 64'(bus.fifo_wen),   64'd0);
      checkOutput("midrst grant",    64'(bus.grant),      64'd0);
      checkOutput("midrst ready0",   64'(bus.req0_ready), 64'd0);
      checkOutput("midrst frames0",  64'(bus.frames0),    64'd0);
      @(negedge clk);
      #1;
      checkOutput("midrst wen held", 64'(bus.fifo_wen), 64'd0);
      rst_n          = 1'b1;
      bus.req0_valid = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("postrst fifo_wen", 64'(bus.fifo_wen), 64'd0);
      checkOutput("postrst grant",    64'(bus.grant),    64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
